// File: rtl/printer_cycle_ctl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// printer_cycle_ctl_pkg : shared types and defaults for the printer cycle ctl
// Rev 1.0
// ============================================================================
package printer_cycle_ctl_pkg;

  localparam int         CNT_W          = 16;
  localparam logic [7:0] DEF_SPACE_CODE = 8'h40;
  localparam logic [7:0] DEF_CR_CODE    = 8'h15;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_DECIDE = 3'd2,
    ST_FIRE   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OP_PRINT      = 3'd0,
    OP_SHIFT_UP   = 3'd1,
    OP_SHIFT_DOWN = 3'd2,
    OP_SPACE      = 3'd3,
    OP_CR         = 3'd4
  } op_e;

endpackage
`default_nettype wire

// File: rtl/printer_cycle_ctl_done_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// cycle_done_sync : 2-flop synchroniser with rising-edge pulse output
// Rev 1.0
// ============================================================================
module cycle_done_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], i_async};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  // sync_q[1] is the first metastability-safe stage, sync_q[2] its history
  assign o_rise = sync_q[1] & ~sync_q[2];

endmodule
`default_nettype wire

// File: rtl/printer_cycle_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// printer_cycle_ctl : one 1052/2150 print/shift/space/CR cycle per character
// Rev 1.0
// ============================================================================
module printer_cycle_ctl
  import printer_cycle_ctl_pkg::*;
#(
  parameter int unsigned MAG_PULSE_CYC = 16,
  parameter int unsigned TIMEOUT_CYC   = 4096,
  parameter logic [7:0]  SPACE_CODE    = DEF_SPACE_CODE,
  parameter logic [7:0]  CR_CODE       = DEF_CR_CODE
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_char_valid,
  output logic       o_char_ready,
  input  logic [7:0] i_data_reg,
  input  logic [5:0] i_tt_code,
  input  logic       i_lower_case_character,
  input  logic       i_upper_case_character,
  input  logic       i_cycle_done,
  input  logic       i_error_clear,
  output logic [5:0] o_tt_mag,
  output logic       o_print_mag,
  output logic       o_shift_up_mag,
  output logic       o_shift_down_mag,
  output logic       o_space_mag,
  output logic       o_cr_mag,
  output logic       o_upper_shift,
  output logic       o_invalid,
  output logic       o_busy,
  output logic       o_error
);

  localparam logic [7:0]       c_pulse_last = 8'(MAG_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] c_tmo_last   = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [7:0]       data_q, data_d;
  logic [5:0]       tt_q, tt_d;
  logic             lower_q, lower_d;
  logic             upper_flag_q, upper_flag_d;
  logic             case_up_q, case_up_d;
  logic             pend_print_q, pend_print_d;
  logic             edge_seen_q, edge_seen_d;
  logic [7:0]       pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             invalid_q, invalid_d;
  logic             w_done_rise;
  logic             w_start_fire;
  logic             w_complete;
  logic             w_is_shift;

  cycle_done_sync u_done_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_cycle_done),
    .o_rise  (w_done_rise)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_INIT;
      op_q         <= OP_PRINT;
      data_q       <= 8'h00;
      tt_q         <= 6'h00;
      lower_q      <= 1'b0;
      upper_flag_q <= 1'b0;
      case_up_q    <= 1'b0;
      pend_print_q <= 1'b0;
      edge_seen_q  <= 1'b0;
      pulse_cnt_q  <= 8'h00;
      tmo_cnt_q    <= '0;
      invalid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      data_q       <= data_d;
      tt_q         <= tt_d;
      lower_q      <= lower_d;
      upper_flag_q <= upper_flag_d;
      case_up_q    <= case_up_d;
      pend_print_q <= pend_print_d;
      edge_seen_q  <= edge_seen_d;
      pulse_cnt_q  <= pulse_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      invalid_q    <= invalid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    data_d       = data_q;
    tt_d         = tt_q;
    lower_d      = lower_q;
    upper_flag_d = upper_flag_q;
    case_up_d    = case_up_q;
    pend_print_d = pend_print_q;
    edge_seen_d  = edge_seen_q;
    pulse_cnt_d  = pulse_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    invalid_d    = 1'b0;
    w_start_fire = 1'b0;
    w_complete   = 1'b0;
    w_is_shift   = (op_q == OP_SHIFT_UP) || (op_q == OP_SHIFT_DOWN);

    unique case (state_q)
      ST_INIT: begin
        op_d         = OP_SHIFT_DOWN;
        pend_print_d = 1'b0;
        w_start_fire = 1'b1;
      end
      ST_IDLE: begin
        if (i_char_valid) begin
          data_d       = i_data_reg;
          tt_d         = i_tt_code;
          lower_d      = i_lower_case_character;
          upper_flag_d = i_upper_case_character;
          state_d      = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        pend_print_d = 1'b0;
        w_start_fire = 1'b1;
        if (data_q == SPACE_CODE) begin
          op_d = OP_SPACE;
        end else if (data_q == CR_CODE) begin
          op_d = OP_CR;
        end else if (lower_q && case_up_q) begin
          op_d         = OP_SHIFT_DOWN;
          pend_print_d = 1'b1;
        end else if (upper_flag_q && !lower_q && !case_up_q) begin
          // lower flag takes precedence when both are set
          op_d         = OP_SHIFT_UP;
          pend_print_d = 1'b1;
        end else if (lower_q || upper_flag_q) begin
          op_d = OP_PRINT;
        end else begin
          w_start_fire = 1'b0;
          invalid_d    = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_FIRE: begin
        if (w_done_rise) begin
          edge_seen_d = 1'b1;
        end
        if (pulse_cnt_q == 8'h00) begin
          if (edge_seen_q || w_done_rise) begin
            w_complete = 1'b1;
          end else begin
            state_d   = ST_WAIT;
            tmo_cnt_d = '0;
          end
        end else begin
          pulse_cnt_d = pulse_cnt_q - 8'd1;
        end
      end
      ST_WAIT: begin
        if (w_done_rise) begin
          w_complete = 1'b1;
        end else if (tmo_cnt_q == c_tmo_last) begin
          state_d = ST_ERROR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      ST_ERROR: begin
        if (i_error_clear) begin
          state_d = ST_INIT;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // A finished shift cycle chains straight into its pending print cycle
    if (w_complete) begin
      state_d = ST_IDLE;
      if (w_is_shift) begin
        case_up_d = (op_q == OP_SHIFT_UP);
        if (pend_print_q) begin
          op_d         = OP_PRINT;
          pend_print_d = 1'b0;
          w_start_fire = 1'b1;
        end
      end
    end

    if (w_start_fire) begin
      state_d     = ST_FIRE;
      pulse_cnt_d = c_pulse_last;
      edge_seen_d = 1'b0;
    end
  end

  always_comb begin
    o_print_mag      = 1'b0;
    o_shift_up_mag   = 1'b0;
    o_shift_down_mag = 1'b0;
    o_space_mag      = 1'b0;
    o_cr_mag         = 1'b0;
    if (state_q == ST_FIRE) begin
      unique case (op_q)
        OP_PRINT:      o_print_mag      = 1'b1;
        OP_SHIFT_UP:   o_shift_up_mag   = 1'b1;
        OP_SHIFT_DOWN: o_shift_down_mag = 1'b1;
        OP_SPACE:      o_space_mag      = 1'b1;
        OP_CR:         o_cr_mag         = 1'b1;
        default:       o_print_mag      = 1'b0;
      endcase
    end
    o_tt_mag      = ((state_q == ST_FIRE) && (op_q == OP_PRINT)) ? tt_q : 6'h00;
    o_char_ready  = (state_q == ST_IDLE);
    o_busy        = (state_q != ST_IDLE) && (state_q != ST_ERROR);
    o_error       = (state_q == ST_ERROR);
    o_upper_shift = case_up_q;
    o_invalid     = invalid_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_printer_cycle_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_printer_cycle_ctl : randomized self-checking bench with timeline model
// Rev 1.0
// ============================================================================
module tb_printer_cycle_ctl;

  localparam int PULSE = 16;
  localparam int TMO   = 4096;
  localparam int K_PRINT = 0, K_UP = 1, K_DOWN = 2, K_SP = 3, K_CR = 4;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_char_valid = 1'b0;
  logic [7:0] i_data_reg = 8'h00;
  logic [5:0] i_tt_code = 6'h00;
  logic       i_lower = 1'b0;
  logic       i_upper = 1'b0;
  logic       i_cycle_done = 1'b0;
  logic       i_error_clear = 1'b0;
  logic       o_char_ready;
  logic [5:0] o_tt_mag;
  logic       o_print_mag, o_shift_up_mag, o_shift_down_mag, o_space_mag, o_cr_mag;
  logic       o_upper_shift, o_invalid, o_busy, o_error;

  printer_cycle_ctl #(
    .MAG_PULSE_CYC (PULSE),
    .TIMEOUT_CYC   (TMO),
    .SPACE_CODE    (8'h40),
    .CR_CODE       (8'h15)
  ) dut (
    .i_clk                  (clk),
    .i_reset                (i_reset),
    .i_char_valid           (i_char_valid),
    .o_char_ready           (o_char_ready),
    .i_data_reg             (i_data_reg),
    .i_tt_code              (i_tt_code),
    .i_lower_case_character (i_lower),
    .i_upper_case_character (i_upper),
    .i_cycle_done           (i_cycle_done),
    .i_error_clear          (i_error_clear),
    .o_tt_mag               (o_tt_mag),
    .o_print_mag            (o_print_mag),
    .o_shift_up_mag         (o_shift_up_mag),
    .o_shift_down_mag       (o_shift_down_mag),
    .o_space_mag            (o_space_mag),
    .o_cr_mag               (o_cr_mag),
    .o_upper_shift          (o_upper_shift),
    .o_invalid              (o_invalid),
    .o_busy                 (o_busy),
    .o_error                (o_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_a [int];   // expected outputs keyed by cycle number
  int dq[$];                  // cycles at which the done contact closes
  int hold = 0;
  logic m_upper = 1'b0;

  // Output vector: {tt[5:0], print, up, down, space, cr, upper, invalid, busy, error, ready}
  function automatic logic [15:0] e_fire(int k, logic [5:0] tt, logic up);
    return {(k == K_PRINT) ? tt : 6'd0, (k == K_PRINT), (k == K_UP), (k == K_DOWN),
            (k == K_SP), (k == K_CR), up, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction
  function automatic logic [15:0] e_busy(logic up);
    return {6'd0, 5'd0, up, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction
  function automatic logic [15:0] e_idle(logic up, logic inv);
    return {6'd0, 5'd0, up, inv, 1'b0, 1'b0, 1'b1};
  endfunction
  function automatic logic [15:0] e_err(logic up);
    return {6'd0, 5'd0, up, 1'b0, 1'b0, 1'b1, 1'b0};
  endfunction

  always @(negedge clk) begin
    logic [15:0] act;
    act = {o_tt_mag, o_print_mag, o_shift_up_mag, o_shift_down_mag, o_space_mag, o_cr_mag,
           o_upper_shift, o_invalid, o_busy, o_error, o_char_ready};
    if (exp_a.exists(cyc)) begin
      checks++;
      if (act !== exp_a[cyc]) begin
        failures++;
        $display("FAIL outputs cyc=%0d act=%h exp=%h", cyc, act, exp_a[cyc]);
      end
    end
  end

  // Done contact: closes on the queued cycle and stays closed three cycles
  always @(posedge clk) begin
    #1;
    while (dq.size() > 0 && dq[0] < cyc) void'(dq.pop_front());
    if (hold > 0) begin
      hold--;
      if (hold == 0) i_cycle_done = 1'b0;
    end
    if (dq.size() > 0 && dq[0] == cyc) begin
      void'(dq.pop_front());
      i_cycle_done = 1'b1;
      hold = 3;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (!exp_a.exists(cyc)) exp_a[cyc] = e_idle(m_upper, 1'b0);
      tick();
    end
  endtask

  // Timeline of one magnet pulse starting at cycle st, done seen in cycle dsee.
  // x = first cycle after the operation, or -(error cycle) on timeout.
  task automatic fire(input int st, input int k, input logic [5:0] tt, input int dsee, output int x);
    bit got;
    got = 1'b0;
    x = 0;
    for (int i = 0; i < PULSE; i++) exp_a[st + i] = e_fire(k, tt, m_upper);
    if (dsee >= st && dsee < st + PULSE) begin
      x = st + PULSE;
    end else begin
      for (int w = st + PULSE; w < st + PULSE + TMO; w++) begin
        if (!got) begin
          exp_a[w] = e_busy(m_upper);
          if (w == dsee) begin
            got = 1'b1;
            x = w + 1;
          end
        end
      end
      if (!got) x = -(st + PULSE + TMO);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    exp_a.delete();
    dq.delete();
    hold = 0;
    i_cycle_done = 1'b0;
    i_char_valid = 1'b0;
    m_upper = 1'b0;
    exp_a[cyc] = {6'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tick();
    exp_a[cyc] = {6'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tick();
    i_reset = 1'b0;
  endtask

  // INIT cycle d; off < 0 means the contact never closes
  task automatic do_init(input int d, input int off, output int x);
    int dsee;
    exp_a[d] = e_busy(m_upper);
    dsee = (off < 0) ? 32'h7fff_ffff : d + 1 + off;
    if (off >= 0) dq.push_back(dsee - 2);
    fire(d + 1, K_DOWN, 6'd0, dsee, x);
    if (x > 0) begin
      m_upper = 1'b0;
      exp_a[x] = e_idle(1'b0, 1'b0);
    end else begin
      exp_a[-x] = e_err(m_upper);
    end
  endtask

  task automatic do_char(input logic [7:0] data, input logic [5:0] tt, input logic lo,
                         input logic up, input int off1, input int off2, input bit pin_en,
                         input logic [10:0] pin, input int abort);
    int c, d, k, x, ds;
    bit sh, inv;
    c = cyc;
    if (!exp_a.exists(c)) exp_a[c] = e_idle(m_upper, 1'b0);
    i_char_valid = 1'b1;
    i_data_reg = data;
    i_tt_code = tt;
    i_lower = lo;
    i_upper = up;
    d = c + 1;
    exp_a[d] = e_busy(m_upper);
    sh = 1'b0;
    inv = 1'b0;
    k = K_PRINT;
    if (data == 8'h40) k = K_SP;
    else if (data == 8'h15) k = K_CR;
    else if (lo && m_upper) begin k = K_DOWN; sh = 1'b1; end
    else if (up && !lo && !m_upper) begin k = K_UP; sh = 1'b1; end
    else if (!(lo || up)) inv = 1'b1;
    tick();
    i_char_valid = 1'b0;
    i_data_reg = 8'($urandom);
    i_lower = 1'($urandom);
    i_upper = 1'($urandom);
    if (inv) begin
      exp_a[d + 1] = e_idle(m_upper, 1'b1);
      wait_to(d + 1);
      return;
    end
    ds = d + 1 + off1;
    dq.push_back(ds - 2);
    fire(d + 1, k, tt, ds, x);
    if (pin_en) begin
      wait_to(d + 1);
      chk("first_pulse_mags", {o_tt_mag, o_print_mag, o_shift_up_mag, o_shift_down_mag,
                               o_space_mag, o_cr_mag}, pin);
    end
    if (abort >= 0) begin
      wait_to(d + 1 + abort);
      return;
    end
    if (sh) begin
      m_upper = (k == K_UP);
      ds = x + off2;
      dq.push_back(ds - 2);
      fire(x, K_PRINT, tt, ds, x);
    end
    exp_a[x] = e_idle(m_upper, 1'b0);
    wait_to(x);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, x, e;
    logic prev_up;
    tick();
    do_reset();

    // INIT downshift with no contact closure: timeout into ERROR
    r = cyc;
    do_init(r, -1, x);
    wait_to(r + 1);
    chk("init_down_start", o_shift_down_mag, 1);
    wait_to(r + 16);
    chk("init_down_last", o_shift_down_mag, 1);
    wait_to(r + 17);
    chk("init_down_end", o_shift_down_mag, 0);
    wait_to(r + 16 + 4096);
    chk("err_before_timeout", o_error, 0);
    chk("ready_low_init", o_char_ready, 0);
    wait_to(r + 17 + 4096);
    chk("err_at_timeout", o_error, 1);
    for (int i = 0; i < 3; i++) begin
      exp_a[cyc] = e_err(m_upper);
      tick();
    end
    i_error_clear = 1'b1;
    exp_a[cyc] = e_err(m_upper);
    tick();
    i_error_clear = 1'b0;
    do_init(cyc, 10, x);
    wait_to(x);
    idle_cycles(2);

    // Lower-case print from lower case: no shift
    do_char(8'h81, 6'b010011, 1'b1, 1'b0, 8, 0, 1'b1, {6'b010011, 5'b10000}, -1);
    chk("upper_after_lc", o_upper_shift, 0);
    idle_cycles(1);
    // Upshift then print: done at last pulse cycle, then in WAIT
    do_char(8'hC1, 6'b100101, 1'b0, 1'b1, 15, 25, 1'b1, {6'd0, 5'b01000}, -1);
    chk("upper_after_uc", o_upper_shift, 1);
    do_char(8'h81, 6'b000111, 1'b1, 1'b0, 20, 10, 1'b1, {6'd0, 5'b00100}, -1);
    chk("upper_after_down", o_upper_shift, 0);
    do_char(8'h40, 6'b111111, 1'b0, 1'b1, 9, 0, 1'b1, {6'd0, 5'b00010}, -1);
    do_char(8'h15, 6'b101010, 1'b0, 1'b1, 30, 0, 1'b1, {6'd0, 5'b00001}, -1);
    chk("upper_after_sp_cr", o_upper_shift, 0);
    // Both flags from upper case: lower wins, downshift
    do_char(8'hC2, 6'b000011, 1'b0, 1'b1, 6, 6, 1'b0, 11'd0, -1);
    do_char(8'h82, 6'b000011, 1'b1, 1'b1, 7, 7, 1'b1, {6'd0, 5'b00100}, -1);
    do_char(8'h07, 6'b000001, 1'b0, 1'b0, 0, 0, 1'b0, 11'd0, -1);
    chk("invalid_pulse", o_invalid, 1);
    chk("invalid_ready", o_char_ready, 1);
    tick();
    chk("invalid_one_cycle", o_invalid, 0);

    // Contact closing while idle must be ignored
    dq.push_back(cyc + 1);
    idle_cycles(8);

    for (int n = 0; n < 30; n++) begin
      int sel;
      logic [7:0] dat;
      sel = $urandom_range(0, 9);
      dat = (sel == 0) ? 8'h40 : (sel == 1) ? 8'h15 : 8'($urandom);
      prev_up = m_upper;
      do_char(dat, 6'($urandom), 1'($urandom), 1'($urandom), $urandom_range(5, 40),
              $urandom_range(6, 40), 1'b0, 11'd0, -1);
      idle_cycles($urandom_range(0, 3));
    end

    // Reset during the fifth cycle of a print pulse
    do_char(8'h91, 6'b110011, 1'b1, 1'b0, 30, 0, 1'b0, 11'd0, 4);
    i_reset = 1'b1;
    #1;
    chk("rst_drops_mags", {o_tt_mag, o_print_mag, o_shift_up_mag, o_shift_down_mag,
                           o_space_mag, o_cr_mag}, 0);
    chk("rst_upper", o_upper_shift, 0);
    do_reset();
    r = cyc;
    do_init(r, 7, x);
    wait_to(r + 1);
    chk("reinit_down", o_shift_down_mag, 1);
    wait_to(x);
    idle_cycles(2);
    do_char(8'hA5, 6'b011110, 1'b1, 1'b0, 12, 0, 1'b1, {6'b011110, 5'b10000}, -1);
    idle_cycles(2);
    e = failures;
    $display("TB_RESULT checks=%0d failures=%0d", checks, e);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/printer_cycle_ctl.md
Name: printer_cycle_ctl

Overview:
- Sequences one 1052/2150 printer operation per accepted character.
- Takes the 8-bit data register and the printer translator's tilt/rotate code and case flags.
- Decides whether a shift cycle is needed and fires the print, shift, space or carrier-return magnets with timed pulses.
- Waits for the machine's cycle-complete contact and flags hung cycles. Sits between the adapter data register and the printer magnet drivers.

Parameters:
MAG_PULSE_CYC, 16, magnet pulse width in clocks (1..255)
TIMEOUT_CYC, 4096, clocks allowed after pulse end for cycle-complete (1..65535)
SPACE_CODE, 8'h40, data value that produces a space cycle
CR_CODE, 8'h15, data value that produces a carrier-return cycle

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_char_valid  in  1  character offered
o_char_ready  out  1  block can accept a character
i_data_reg  in  8  data register byte
i_tt_code  in  6  {T1,T2,R1,R2,R2A,R5} from the translator
i_lower_case_character  in  1  translator lower-case flag
i_upper_case_character  in  1  translator upper-case flag
i_cycle_done  in  1  cycle-complete contact, asynchronous to i_clk
i_error_clear  in  1  clears the error state
o_tt_mag  out  6  tilt/rotate magnets
o_print_mag  out  1  print cycle clutch magnet
o_shift_up_mag  out  1  upshift magnet
o_shift_down_mag  out  1  downshift magnet
o_space_mag  out  1  space magnet
o_cr_mag  out  1  carrier-return magnet
o_upper_shift  out  1  tracked case state (1 = upper)
o_invalid  out  1  one-cycle pulse: character rejected
o_busy  out  1  operation in progress
o_error  out  1  cycle-complete timeout

Behaviour:
- Reset (asynchronous, immediate): all magnets 0, o_upper_shift=0, o_invalid=0, o_error=0, o_char_ready=0, o_busy=1, state INIT. Reset mid-pulse drops the magnets the same instant.
- INIT: issues one downshift cycle (pulse plus wait, as below). On completion: o_upper_shift=0, go to IDLE. A timeout in INIT goes to ERROR.
- IDLE: o_char_ready=1, o_busy=0.
- Accept on rising edge where i_char_valid && o_char_ready. That edge latches data, tt code and flags, and goes to DECIDE. o_char_ready drops the next cycle.
- DECIDE (one cycle), in priority order:
  - data==SPACE_CODE: space op.
  - data==CR_CODE: CR op.
  - lower flag && o_upper_shift: downshift then print.
  - upper flag && !o_upper_shift: upshift then print.
  - either flag set: print.
  - neither flag: o_invalid pulse for one cycle, return to IDLE.
  - Both flags set: lower wins.
- FIRE: the selected magnet(s) are asserted starting the cycle after DECIDE, for exactly MAG_PULSE_CYC cycles.
  - Print: o_print_mag together with o_tt_mag = latched tt code.
  - o_tt_mag is 0 whenever o_print_mag is 0.
- WAIT: i_cycle_done passes through a 2-flop synchroniser and rising-edge detector.
  - An edge seen during FIRE is latched and honoured at pulse end.
  - The timeout counter (16-bit) starts at pulse end. Reaching TIMEOUT_CYC without an edge goes to ERROR.
- Shift completion: o_upper_shift toggles to the new case on the done edge, then FIRE print begins the next cycle.
- Op completion: returns to IDLE. o_char_ready=1 on the cycle after the final done edge.
- ERROR: all magnets 0, o_error=1, o_char_ready=0. On i_error_clear go to INIT (resynchronise the shift state).
- o_busy=1 in every state except IDLE and ERROR.
- Done edges arriving in IDLE or DECIDE are ignored.

Decomposition:
- Shared package: state enumeration (INIT, IDLE, DECIDE, FIRE, WAIT, ERROR), op-kind enumeration (PRINT, SHIFT_UP, SHIFT_DOWN, SPACE, CR), SPACE_CODE/CR_CODE defaults, counter width constant 16.
- One sub-module: cycle_done_sync (2-flop synchroniser plus rising-edge pulse, async reset to 0).

Test Plan:
- Reset, then hold i_cycle_done low → o_shift_down_mag high for 16 cycles; o_error=1 exactly 4096 cycles after the pulse ends; o_char_ready=0 throughout.
- Reset, done edge after pulse → IDLE. Offer 0x81, lower=1, tt=6'b010011 → o_print_mag and o_tt_mag=6'b010011 from accept+2 for 16 cycles. No shift magnet. o_upper_shift stays 0.
- From lower case, offer 0xC1, upper=1 → o_shift_up_mag 16 cycles. After the done edge, o_upper_shift=1, then o_print_mag 16 cycles. Next 0x81 → downshift precedes print.
- Offer 0x40 → o_space_mag 16 cycles only. Offer 0x15 → o_cr_mag only. o_upper_shift unchanged for both.
- Offer 0x07 with both flags 0 → o_invalid one cycle, no magnets, o_char_ready back at accept+2.
- Assert i_reset at cycle 5 of a print pulse → all magnets 0 immediately, then INIT downshift sequence. A done edge during a pulse is honoured, with the transition at pulse end.
